// File: rtl/cpu_shift_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_shift_ctrl
//
// Execute-stage sequencer for the iterative shifter (cpu_shifter). It accepts
// one decoded shift op from decode and latches all of its fields. It then
// pulses the shifter start for one cycle and waits for the shifter's done.
// When done arrives it captures the result and holds it for writeback until
// the writeback stage accepts it. Decode is stalled (in_ready_o=0) from the
// accept until the writeback handshake has completed.
//
// If the shifter never answers, a watchdog raises a sticky err_o after
// TIMEOUT WAIT cycles and returns a zero result.
//
// Build option:
//   CPU_SHIFT_FASTPATH_EN  when defined, an op whose effective shift amount is
//                          zero skips ISSUE/WAIT. It goes straight to RESP with
//                          wb_data_o = in_src_a_i and no start pulse.
//                          When undefined, every op takes the full sequence.
//
// Parameters:
//   XLEN     datapath width (only 32 is supported)
//   RD_W     destination register index width
//   TIMEOUT  WAIT cycles before err_o is raised (must exceed 32)
//
// Ports:
//   clk_i, rst_ni                  clock (rising edge), async active-low reset
//   in_valid_i / in_ready_o        decode handshake; ready only in IDLE
//   in_src_a_i, in_src_b_i         value to shift, register shift amount
//   in_imm_i, in_use_imm_i         immediate amount (low 5 bits) and its select
//   in_right_i, in_signed_i        direction, arithmetic (right only)
//   in_rd_i                        destination register
//   sh_start_o                     one-cycle start pulse to the shifter
//   sh_src_a_o, sh_src_b_o,
//   sh_imm_o, sh_use_imm_o,
//   sh_right_o, sh_signed_o        latched operands, stable ISSUE..RESP
//   sh_done_i, sh_res_i            shifter completion and result
//   wb_valid_o / wb_ready_i        writeback handshake
//   wb_rd_o, wb_data_o             destination register and result
//   busy_o                         controller is not IDLE
//   err_o                          sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module cpu_shift_ctrl #(
  parameter int XLEN    = 32,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 40
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] in_src_a_i,
  input  logic [XLEN-1:0] in_src_b_i,
  input  logic [XLEN-1:0] in_imm_i,
  input  logic            in_use_imm_i,
  input  logic            in_right_i,
  input  logic            in_signed_i,
  input  logic [RD_W-1:0] in_rd_i,
  output logic            sh_start_o,
  output logic [XLEN-1:0] sh_src_a_o,
  output logic [XLEN-1:0] sh_src_b_o,
  output logic [XLEN-1:0] sh_imm_o,
  output logic            sh_use_imm_o,
  output logic            sh_right_o,
  output logic            sh_signed_o,
  input  logic            sh_done_i,
  input  logic [XLEN-1:0] sh_res_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [RD_W-1:0] wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            busy_o,
  output logic            err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              sh_start_q;
  logic [XLEN-1:0]   src_a_q, src_b_q, imm_q;
  logic              use_imm_q, right_q, signed_q;
  logic [RD_W-1:0]   rd_q;
  logic [XLEN-1:0]   wb_data_q;
  logic              wb_valid_q;
  logic              err_q;

`ifdef CPU_SHIFT_FASTPATH_EN
  // Effective amount is zero when the selected source has no shift in it.
  // For the register path, any bit set anywhere (including the clamp bits
  // 31:6) means a non-zero amount.
  logic in_amt_zero_d;
  assign in_amt_zero_d = in_use_imm_i ? (in_imm_i[4:0] == 5'd0)
                                      : (in_src_b_i == '0);
`endif

  // Sequencer. sh_done_i is only looked at in WAIT: the shifter has no
  // reset, so its done is meaningless outside a start..done window.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      sh_start_q <= 1'b0;
      src_a_q    <= '0;
      src_b_q    <= '0;
      imm_q      <= '0;
      use_imm_q  <= 1'b0;
      right_q    <= 1'b0;
      signed_q   <= 1'b0;
      rd_q       <= '0;
      wb_data_q  <= '0;
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sh_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            src_a_q   <= in_src_a_i;
            src_b_q   <= in_src_b_i;
            imm_q     <= in_imm_i;
            use_imm_q <= in_use_imm_i;
            right_q   <= in_right_i;
            signed_q  <= in_signed_i;
            rd_q      <= in_rd_i;
`ifdef CPU_SHIFT_FASTPATH_EN
            if (in_amt_zero_d) begin
              wb_data_q  <= in_src_a_i;
              wb_valid_q <= 1'b1;
              state_q    <= RESP;
            end else
`endif
            begin
              sh_start_q <= 1'b1;
              state_q    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          // A done in the same cycle as the final count wins over the timeout.
          if (sh_done_i) begin
            wb_data_q  <= sh_res_i;
            wb_valid_q <= 1'b1;
            state_q    <= RESP;
          end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_q      <= 1'b1;
            wb_data_q  <= '0;
            wb_valid_q <= 1'b1;
            state_q    <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (wb_ready_i) begin
            wb_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o   = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign sh_start_o   = sh_start_q;
  assign sh_src_a_o   = src_a_q;
  assign sh_src_b_o   = src_b_q;
  assign sh_imm_o     = imm_q;
  assign sh_use_imm_o = use_imm_q;
  assign sh_right_o   = right_q;
  assign sh_signed_o  = signed_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_rd_o      = rd_q;
  assign wb_data_o    = wb_data_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_cpu_shift_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_shift_ctrl
//
// Scoreboard bench for cpu_shift_ctrl. applyStimulus drives one op. It works
// out the expected result, the response cycle and the number of start pulses
// from the shift rules, then queues that expectation. A separate monitor pops
// the queue whenever a new writeback response appears, and it checks the held
// result on every stalled RESP cycle.
//
// A behavioural shifter answers sh_start_o after the effective amount plus one
// cycle. Outside its busy window it drives random garbage on sh_done_i and
// sh_res_i.
// -----------------------------------------------------------------------------
module tb_cpu_shift_ctrl;

  localparam int XLEN    = 32;
  localparam int RD_W    = 5;
  localparam int TIMEOUT = 40;

  logic            clk;
  logic            rst_ni;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLEN-1:0] in_src_a_i, in_src_b_i, in_imm_i;
  logic            in_use_imm_i, in_right_i, in_signed_i;
  logic [RD_W-1:0] in_rd_i;
  logic            sh_start_o;
  logic [XLEN-1:0] sh_src_a_o, sh_src_b_o, sh_imm_o;
  logic            sh_use_imm_o, sh_right_o, sh_signed_o;
  logic            sh_done_i;
  logic [XLEN-1:0] sh_res_i;
  logic            wb_valid_o;
  logic            wb_ready_i;
  logic [RD_W-1:0] wb_rd_o;
  logic [XLEN-1:0] wb_data_o;
  logic            busy_o;
  logic            err_o;

  cpu_shift_ctrl #(.XLEN(XLEN), .RD_W(RD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_src_a_i(in_src_a_i), .in_src_b_i(in_src_b_i), .in_imm_i(in_imm_i),
    .in_use_imm_i(in_use_imm_i), .in_right_i(in_right_i), .in_signed_i(in_signed_i),
    .in_rd_i(in_rd_i),
    .sh_start_o(sh_start_o), .sh_src_a_o(sh_src_a_o), .sh_src_b_o(sh_src_b_o),
    .sh_imm_o(sh_imm_o), .sh_use_imm_o(sh_use_imm_o), .sh_right_o(sh_right_o),
    .sh_signed_o(sh_signed_o), .sh_done_i(sh_done_i), .sh_res_i(sh_res_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .busy_o(busy_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
    int          cycle;
    int          starts;
    logic [31:0] a, b, imm;
    logic [2:0]  ctrl;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   startCount = 0;
  int   forceStall = 0;
  int   shCnt = -1;
  bit   hangMode = 0;
  bit   stickyErr = 0;
  bit   inResp = 0;
  logic [31:0] pendRes;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Effective amount: imm[4:0], else b[5:0], clamped to 32 when b[31:6] != 0.
  function automatic int effAmt(input logic [31:0] b, input logic [31:0] imm, input logic useImm);
    if (useImm) return int'(imm[4:0]);
    if (b[31:6] != 26'd0) return 32;
    return int'(b[5:0]);
  endfunction

  // Shift through a 64-bit window so that amounts up to 32 fall out naturally.
  function automatic logic [31:0] refShift(input logic [31:0] a, input int n,
                                           input logic right, input logic sgn);
    logic [63:0] wide;
    if (!right) begin
      wide = {32'd0, a} << n;
    end else begin
      wide = {(sgn ? {32{a[31]}} : 32'd0), a} >> n;
    end
    return wide[31:0];
  endfunction

  // Behavioural shifter: done appears N+1 cycles after the start cycle.
  always @(negedge clk) begin
    if (sh_start_o) begin
      shCnt   = hangMode ? -2 : effAmt(sh_src_b_o, sh_imm_o, sh_use_imm_o) + 1;
      pendRes = refShift(sh_src_a_o, effAmt(sh_src_b_o, sh_imm_o, sh_use_imm_o),
                         sh_right_o, sh_signed_o);
      sh_done_i = 1'b0;
      sh_res_i  = $urandom;
    end else if (shCnt > 0) begin
      shCnt = shCnt - 1;
      if (shCnt == 0) begin
        sh_done_i = 1'b1;
        sh_res_i  = pendRes;
        shCnt     = -1;
      end else begin
        sh_done_i = 1'b0;
        sh_res_i  = $urandom;
      end
    end else if (shCnt == -2 && hangMode) begin
      sh_done_i = 1'b0;
      sh_res_i  = $urandom;
    end else begin
      shCnt     = -1;
      sh_done_i = 1'($urandom_range(1));
      sh_res_i  = $urandom;
    end
  end

  // Writeback acceptor: a requested stall first, otherwise random back-pressure.
  always @(negedge clk) begin
    if (wb_valid_o && forceStall > 0) begin
      wb_ready_i = 1'b0;
      forceStall = forceStall - 1;
    end else begin
      wb_ready_i = ($urandom_range(3) != 0);
    end
  end

  // Monitor: a new response pops one expectation; stalled cycles must hold.
  always @(negedge clk) begin
    if (sh_start_o) startCount = startCount + 1;
    if (rst_ni && wb_valid_o) begin
      if (!inResp) begin
        inResp = 1'b1;
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_response: got data 0x%08h, expected no response", wb_data_o);
        end else begin
          cur = expQ.pop_front();
          checkOutput("wb_data", wb_data_o, cur.data);
          checkOutput("wb_rd", 32'(wb_rd_o), 32'(cur.rd));
          checkOutput("err", 32'(err_o), 32'(cur.err));
          checkOutput("latency_cycle", 32'(cyc), 32'(cur.cycle));
          checkOutput("start_pulses", 32'(startCount), 32'(cur.starts));
          if (cur.starts == 1) begin
            checkOutput("sh_src_a", sh_src_a_o, cur.a);
            checkOutput("sh_src_b", sh_src_b_o, cur.b);
            checkOutput("sh_imm", sh_imm_o, cur.imm);
            checkOutput("sh_ctrl", 32'({sh_use_imm_o, sh_right_o, sh_signed_o}), 32'(cur.ctrl));
          end
          startCount = 0;
        end
      end else begin
        checkOutput("wb_data_hold", wb_data_o, cur.data);
        checkOutput("wb_rd_hold", 32'(wb_rd_o), 32'(cur.rd));
      end
      checkOutput("in_ready_in_resp", 32'(in_ready_o), 32'd0);
    end else begin
      inResp = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                               input logic useImm, input logic right, input logic sgn,
                               input logic [4:0] rd);
    exp_t e;
    int   n;
    int   lat;
    int   waitCnt = 0;
    bit   to;
    @(negedge clk);
    while (!in_ready_o && waitCnt < 300) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready_o) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_wait: in_ready_o got 0, expected 1");
      return;
    end
    n  = effAmt(b, imm, useImm);
    to = hangMode;
`ifdef CPU_SHIFT_FASTPATH_EN
    if (n == 0) begin
      lat      = 1;
      e.starts = 0;
      to       = 1'b0;
    end else
`endif
    begin
      lat      = to ? TIMEOUT + 2 : n + 3;
      e.starts = 1;
    end
    e.data  = to ? 32'd0 : refShift(a, n, right, sgn);
    e.rd    = rd;
    e.err   = stickyErr | to;
    stickyErr = e.err;
    e.cycle = cyc + lat;
    e.a     = a;
    e.b     = b;
    e.imm   = imm;
    e.ctrl  = {useImm, right, sgn};
    expQ.push_back(e);
    in_src_a_i   = a;
    in_src_b_i   = b;
    in_imm_i     = imm;
    in_use_imm_i = useImm;
    in_right_i   = right;
    in_signed_i  = sgn;
    in_rd_i      = rd;
    in_valid_i   = 1'b1;
    @(negedge clk);
    in_valid_i   = 1'b0;
    in_src_a_i   = $urandom;
    in_src_b_i   = $urandom;
    in_imm_i     = $urandom;
    in_use_imm_i = 1'($urandom_range(1));
    in_right_i   = 1'($urandom_range(1));
    in_signed_i  = 1'($urandom_range(1));
    in_rd_i      = 5'($urandom);
  endtask

  task automatic waitDrain();
    int budget = 0;
    while ((expQ.size() != 0 || !in_ready_o) && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    if (expQ.size() != 0 || !in_ready_o) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending responses, expected 0", expQ.size());
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rb;
    rst_ni = 1'b0;
    in_valid_i = 1'b0;
    in_src_a_i = '0; in_src_b_i = '0; in_imm_i = '0;
    in_use_imm_i = 1'b0; in_right_i = 1'b0; in_signed_i = 1'b0; in_rd_i = '0;
    sh_done_i = 1'b0; sh_res_i = '0; wb_ready_i = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_wb_valid", 32'(wb_valid_o), 32'd0);
    checkOutput("reset_err", 32'(err_o), 32'd0);
    checkOutput("reset_start", 32'(sh_start_o), 32'd0);
    checkOutput("reset_wb_data", wb_data_o, 32'd0);
    checkOutput("reset_sh_src_a", sh_src_a_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_in_ready", 32'(in_ready_o), 32'd1);

    // Directed cases
    applyStimulus(32'h0000_00F1, 32'h0, 32'h4, 1'b1, 1'b0, 1'b0, 5'd3);
    applyStimulus(32'h8000_0000, 32'd31, 32'h0, 1'b0, 1'b1, 1'b1, 5'd4);
    applyStimulus(32'h8000_0000, 32'd31, 32'h0, 1'b0, 1'b1, 1'b0, 5'd5);
    applyStimulus(32'hDEAD_BEEF, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 1'b0, 5'd6);
    waitDrain();
    forceStall = 5;
    applyStimulus(32'hCAFE_0001, 32'd7, 32'h0, 1'b0, 1'b0, 1'b0, 5'd7);
    applyStimulus(32'h1234_5678, 32'h0, 32'hFFFF_FFE0, 1'b1, 1'b1, 1'b0, 5'd8);
    applyStimulus(32'h1234_5678, 32'h0, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 5'd9);

    // Random ops
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(2))
        0:       rb = 32'($urandom_range(32));
        1:       rb = $urandom | 32'h0000_0040;
        default: rb = 32'($urandom_range(8));
      endcase
      if ($urandom_range(5) == 0) begin
        waitDrain();
        forceStall = int'($urandom_range(6));
      end
      applyStimulus($urandom, rb, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)),
                    1'($urandom_range(1)), 5'($urandom));
    end
    waitDrain();

    // Shifter never answers: timeout, zero data, sticky error
    hangMode = 1'b1;
    applyStimulus(32'hFFFF_FFFF, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0, 5'd10);
    waitDrain();
    hangMode = 1'b0;
    applyStimulus(32'h0000_0001, 32'h0, 32'h2, 1'b1, 1'b0, 1'b0, 5'd11);
    waitDrain();
    checkOutput("err_sticky", 32'(err_o), 32'd1);

    // Reset in the middle of WAIT aborts the op and clears the error
    applyStimulus(32'hA5A5_A5A5, 32'd32, 32'h0, 1'b0, 1'b1, 1'b0, 5'd12);
    repeat (6) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    checkOutput("midop_reset_busy", 32'(busy_o), 32'd0);
    checkOutput("midop_reset_wb_valid", 32'(wb_valid_o), 32'd0);
    checkOutput("midop_reset_err", 32'(err_o), 32'd0);
    if (expQ.size() != 0) expQ.delete(expQ.size() - 1);
    stickyErr = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    startCount = 0;
    @(negedge clk);
    checkOutput("after_reset_in_ready", 32'(in_ready_o), 32'd1);
    applyStimulus(32'h0F0F_0F0F, 32'd2, 32'h0, 1'b0, 1'b0, 1'b0, 5'd13);
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
